imem_boot_loader: RTL

- Byte-stream boot controller that sequences instruction-memory programming ahead of the fetch stage.
- Receives framed bytes from a host link (UART receiver) and assembles little-endian 32-bit words.
- Drives the instruction memory programming port (prog_en / prog_addr / prog_data).
- Asserts start to release the program counter and fetch stage only after a frame with a valid checksum.

---
 rtl/imem_boot_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: parses framed host bytes (sync, length, little-endian words, XOR checksum)
// into instruction-memory writes and releases the core only after a clean frame.
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 4096,
    parameter int unsigned TIMEOUT   = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        prog_en,
    output logic [31:0] prog_addr,
    output logic [31:0] prog_data,
    output logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE, ST_CSUM, ST_DONE, ST_ERROR
    } state_t;

    state_t         state_reg, state_next;
    logic [15:0]    len_reg, len_next;
    logic [1:0]     byte_cnt_reg, byte_cnt_next;
    logic [31:0]    word_reg, word_next;
    logic [7:0]     csum_reg, csum_next;
    logic [TW-1:0]  timeout_reg, timeout_next;
    logic [15:0]    words_reg, words_next;
    logic [31:0]    addr_reg, addr_next;
    logic [31:0]    data_reg, data_next;
    logic           error_reg, error_next;

    logic           accept;
    logic           busy_w;
    logic [15:0]    len_full;
    logic [31:0]    word_shift;

    // New byte enters at the top; after four bytes the first one sits in bits 7:0.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        assign word_shift[8*gi +: 8] = word_reg[8*(gi+1) +: 8];
    end
    assign word_shift[31:24] = byte_data;

    assign len_full = {byte_data, len_reg[7:0]};
    assign accept   = byte_valid && byte_ready;
    assign busy_w   = (state_reg == ST_LEN_LO) || (state_reg == ST_LEN_HI) ||
                      (state_reg == ST_DATA)   || (state_reg == ST_WRITE)  ||
                      (state_reg == ST_CSUM);

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        byte_cnt_next = byte_cnt_reg;
        word_next     = word_reg;
        csum_next     = csum_reg;
        timeout_next  = '0;
        words_next    = words_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        error_next    = error_reg;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (accept && byte_data == SYNC_BYTE) begin
                    state_next    = ST_LEN_LO;
                    error_next    = 1'b0;
                    words_next    = '0;
                    csum_next     = '0;
                    byte_cnt_next = '0;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_next[7:0] = byte_data;
                    state_next    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_next = len_full;
                    if (len_full == 16'd0 || 32'(len_full) > MAX_WORDS) begin
                        state_next = ST_ERROR;
                        error_next = 1'b1;
                    end else begin
                        state_next    = ST_DATA;
                        byte_cnt_next = '0;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    word_next     = word_shift;
                    csum_next     = csum_reg ^ byte_data;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        // Latch address/data now so they are steady for the whole strobe.
                        addr_next  = BASE_ADDR + {14'd0, words_reg, 2'b00};
                        data_next  = word_shift;
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (words_reg < len_reg) begin
                    words_next = words_reg + 16'd1;
                end
                if (({1'b0, words_reg} + 17'd1) < {1'b0, len_reg}) begin
                    state_next = ST_DATA;
                end else begin
                    state_next = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (byte_data == csum_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ERROR;
                        error_next = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Inter-byte watchdog; a WRITE cycle counts as link activity.
        if (busy_w && !accept && state_reg != ST_WRITE) begin
            if (timeout_reg == TIMEOUT_LAST) begin
                state_next = ST_ERROR;
                error_next = 1'b1;
            end else begin
                timeout_next = timeout_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            len_reg      <= '0;
            byte_cnt_reg <= '0;
            word_reg     <= '0;
            csum_reg     <= '0;
            timeout_reg  <= '0;
            words_reg    <= '0;
            addr_reg     <= BASE_ADDR;
            data_reg     <= '0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            byte_cnt_reg <= byte_cnt_next;
            word_reg     <= word_next;
            csum_reg     <= csum_next;
            timeout_reg  <= timeout_next;
            words_reg    <= words_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            error_reg    <= error_next;
        end
    end

    assign byte_ready   = (state_reg != ST_WRITE);
    assign prog_en      = (state_reg == ST_WRITE);
    assign prog_addr    = addr_reg;
    assign prog_data    = data_reg;
    assign start        = (state_reg == ST_DONE);
    assign done         = (state_reg == ST_DONE);
    assign busy         = busy_w;
    assign error        = error_reg;
    assign words_loaded = words_reg;

endmodule
